// File: rtl/keypad_scan_ctrl.sv
// Column-scan controller for a 4x4 hex keypad: debounces the any-row indication,
// walks a one-hot column to locate the key, strobes its code, and waits for release.
module keypad_scan_ctrl #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int SETTLE_CYCLES   = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       s_row,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] code,
  output logic       key_valid,
  output logic       key_down
);

  typedef enum logic [2:0] {
    S_IDLE, S_DEB, S_SCAN0, S_SCAN1, S_SCAN2, S_SCAN3, S_HOLD
  } state_t;

  localparam logic [15:0] DEB_LAST = 16'(DEBOUNCE_CYCLES - 1);
  localparam logic [15:0] SET_LAST = 16'(SETTLE_CYCLES - 1);

  state_t      r_state, w_state_nxt;
  logic [15:0] r_cnt, w_cnt_nxt;
  logic [3:0]  r_row_q1, r_row_q2;
  logic [3:0]  r_col, w_col_nxt;
  logic [3:0]  r_code, w_code_nxt;
  logic        r_valid, r_down;
  logic [1:0]  w_j, w_row_idx;
  logic        w_hit;
  state_t      w_scan_next;

  // Row sync pipeline gives row_q; the settle window absorbs its latency.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_row_q1 <= 4'h0;
      r_row_q2 <= 4'h0;
    end else begin
      r_row_q1 <= row;
      r_row_q2 <= r_row_q1;
    end
  end

  always_comb begin
    w_j         = 2'd0;
    w_scan_next = S_IDLE;
    case (r_state)
      S_SCAN0: begin w_j = 2'd0; w_scan_next = S_SCAN1; end
      S_SCAN1: begin w_j = 2'd1; w_scan_next = S_SCAN2; end
      S_SCAN2: begin w_j = 2'd2; w_scan_next = S_SCAN3; end
      S_SCAN3: begin w_j = 2'd3; w_scan_next = S_IDLE;  end
      default: begin w_j = 2'd0; w_scan_next = S_IDLE;  end
    endcase
  end

  // Lowest active row wins when several keys share the driven column.
  always_comb begin
    w_row_idx = 2'd3;
    if (r_row_q2[0])      w_row_idx = 2'd0;
    else if (r_row_q2[1]) w_row_idx = 2'd1;
    else if (r_row_q2[2]) w_row_idx = 2'd2;
  end

  assign w_hit = s_row && (r_row_q2 != 4'h0);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_code_nxt  = r_code;
    case (r_state)
      S_IDLE: begin
        if (s_row) w_state_nxt = S_DEB;
      end
      S_DEB: begin
        if (!s_row)                w_state_nxt = S_IDLE;
        else if (r_cnt == DEB_LAST) w_state_nxt = S_SCAN0;
        else                       w_cnt_nxt   = r_cnt + 16'd1;
      end
      S_SCAN0, S_SCAN1, S_SCAN2, S_SCAN3: begin
        if (r_cnt == SET_LAST) begin
          if (w_hit) begin
            w_code_nxt  = {w_row_idx, w_j};
            w_state_nxt = S_HOLD;
          end else begin
            w_state_nxt = w_scan_next;
          end
        end else begin
          w_cnt_nxt = r_cnt + 16'd1;
        end
      end
      S_HOLD: begin
        // Release needs an unbroken run of low samples; any high restarts it.
        if (s_row)                  w_cnt_nxt   = 16'd0;
        else if (r_cnt == DEB_LAST) w_state_nxt = S_IDLE;
        else                        w_cnt_nxt   = r_cnt + 16'd1;
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (w_state_nxt != r_state) w_cnt_nxt = 16'd0;
  end

  // Column drive follows the next state so it is registered with it.
  always_comb begin
    w_col_nxt = 4'b1111;
    case (w_state_nxt)
      S_SCAN0: w_col_nxt = 4'b0001;
      S_SCAN1: w_col_nxt = 4'b0010;
      S_SCAN2: w_col_nxt = 4'b0100;
      S_SCAN3: w_col_nxt = 4'b1000;
      S_HOLD:  w_col_nxt = r_col;
      default: w_col_nxt = 4'b1111;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= 16'd0;
      r_col   <= 4'b1111;
      r_code  <= 4'h0;
      r_valid <= 1'b0;
      r_down  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_col   <= w_col_nxt;
      r_code  <= w_code_nxt;
      r_valid <= (w_state_nxt == S_HOLD) && (r_state != S_HOLD);
      r_down  <= (w_state_nxt == S_HOLD);
    end
  end

  assign col       = r_col;
  assign code      = r_code;
  assign key_valid = r_valid;
  assign key_down  = r_down;

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Bench for keypad_scan_ctrl: a keypad matrix plus 2-flop synchronizer model drives
// the DUT; expected codes and cycle timing are computed from the press/scan rules.
module tb_keypad_scan_ctrl;
  localparam int D = 4;
  localparam int S = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        s_row;
  logic [3:0]  row, col, code;
  logic        key_valid, key_down;
  logic [15:0] keys = 16'h0;
  logic [1:0]  sync;
  logic        force1 = 1'b0, force0 = 1'b0;
  int          cyc = 0, n_chk = 0, n_err = 0, n_strobe = 0;
  logic [3:0]  last_code = 4'h0;

  keypad_scan_ctrl #(.DEBOUNCE_CYCLES(D), .SETTLE_CYCLES(S)) dut (
    .clock(clock), .reset(reset), .s_row(s_row), .row(row), .col(col),
    .code(code), .key_valid(key_valid), .key_down(key_down)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // Key index = 4*row + col; a row line is high if any pressed key in it sits on a driven column.
  always_comb begin
    row = 4'h0;
    for (int r = 0; r < 4; r++) row[r] = |(keys[4*r +: 4] & col);
  end

  always @(posedge clock or posedge reset)
    if (reset) sync <= 2'b00;
    else       sync <= {sync[0], |row};

  assign s_row = (sync[1] | force1) & ~force0;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clock);
    if (key_valid === 1'b1) n_strobe++;
  endtask

  function automatic logic [3:0] oh(input int j);
    logic [3:0] v;
    v = 4'b0001;
    return v << j;
  endfunction

  // Reference: first column in scan order holding a key, then lowest row in it.
  function automatic void model(input logic [15:0] k, output int j, output logic [3:0] cd);
    j = -1; cd = 4'h0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        if (j < 0 && k[4*r + c]) begin
          j  = c;
          cd = 4'((4 * r) + c);
        end
  endfunction

  task automatic press_check(input logic [15:0] k, input bit bounce, input string tag);
    int j, k0, e0, t_hit, c;
    logic [3:0] cd, expc;
    model(k, j, cd);
    tick();
    keys = k;
    k0 = cyc;
    e0 = k0 + 3 + (bounce ? 4 : 0);
    t_hit = e0 + D + (j + 1) * S;
    while (cyc < t_hit + 2) begin
      tick();
      c = cyc;
      if (c < e0 + D)   expc = 4'hF;
      else if (c < t_hit) expc = oh((c - e0 - D) / S);
      else              expc = oh(j);
      chk({tag, "_col"}, {4'h0, col}, {4'h0, expc});
      chk({tag, "_kv"}, {7'h0, key_valid}, {7'h0, (c == t_hit)});
      if (c == t_hit) begin
        chk({tag, "_code"}, {4'h0, code}, {4'h0, cd});
        chk({tag, "_kd"}, {7'h0, key_down}, 8'h1);
      end
      if (bounce && c == k0 + 5) force0 = 1'b1;
      if (bounce && c == k0 + 6) force0 = 1'b0;
    end
    last_code = cd;
  endtask

  task automatic release_check(input string tag);
    int s0;
    tick();
    keys = 16'h0;
    s0 = n_strobe;
    repeat (D + 8) tick();
    chk({tag, "_rel_kd"}, {7'h0, key_down}, 8'h0);
    chk({tag, "_rel_col"}, {4'h0, col}, 8'h0F);
    chk({tag, "_rel_code"}, {4'h0, code}, {4'h0, last_code});
    chk({tag, "_rel_nostrobe"}, 8'(n_strobe - s0), 8'h0);
  endtask

  task automatic reset_pulse(input string tag);
    int s0;
    #1 reset = 1'b1;
    #1;
    chk({tag, "_col"}, {4'h0, col}, 8'h0F);
    chk({tag, "_code"}, {4'h0, code}, 8'h00);
    chk({tag, "_kv"}, {7'h0, key_valid}, 8'h0);
    chk({tag, "_kd"}, {7'h0, key_down}, 8'h0);
    keys = 16'h0;
    last_code = 4'h0;
    repeat (3) tick();
    reset = 1'b0;
    s0 = n_strobe;
    repeat (30) tick();
    chk({tag, "_nostrobe"}, 8'(n_strobe - s0), 8'h0);
    chk({tag, "_post_code"}, {4'h0, code}, 8'h00);
  endtask

  initial begin
    int k0, k1, e0, c, s0, n;
    logic [15:0] rk;

    repeat (2) tick();
    chk("rst_col", {4'h0, col}, 8'h0F);
    chk("rst_code", {4'h0, code}, 8'h00);
    chk("rst_kv", {7'h0, key_valid}, 8'h0);
    chk("rst_kd", {7'h0, key_down}, 8'h0);
    reset = 1'b0;
    repeat (3) tick();

    press_check(16'h0400, 1'b0, "keyA");
    release_check("keyA");

    s0 = n_strobe;
    press_check(16'h0020, 1'b1, "key5");
    release_check("key5");
    chk("key5_one_strobe", 8'(n_strobe - s0), 8'h1);

    // Key F held, then release with a 2-low / 1-high / long-low sequence.
    press_check(16'h8000, 1'b0, "keyF");
    s0 = n_strobe;
    tick(); keys = 16'h0; k1 = cyc;
    tick(); tick(); keys = 16'h8000;
    tick(); keys = 16'h0;
    while (cyc < k1 + 8) tick();
    chk("keyF_held_after_bounce", {7'h0, key_down}, 8'h1);
    while (cyc < k1 + 11) tick();
    chk("keyF_released", {7'h0, key_down}, 8'h0);
    chk("keyF_rel_col", {4'h0, col}, 8'h0F);
    repeat (4) tick();
    chk("keyF_no_extra", 8'(n_strobe - s0), 8'h0);

    press_check(16'h0006, 1'b0, "keys12");
    release_check("keys12");
    press_check(16'h1010, 1'b0, "keys4C");
    release_check("keys4C");

    // s_row pulse with no key in the matrix: full scan misses.
    s0 = n_strobe;
    tick(); force1 = 1'b1; k0 = cyc; e0 = k0 + 1;
    while (cyc < k0 + 24) begin
      tick();
      c = cyc;
      if (c == k0 + 5) force1 = 1'b0;
      if (c < e0 + D || c >= e0 + D + 4 * S)
        chk("miss_col", {4'h0, col}, 8'h0F);
      else
        chk("miss_col", {4'h0, col}, {4'h0, oh((c - e0 - D) / S)});
    end
    chk("miss_nostrobe", 8'(n_strobe - s0), 8'h0);
    chk("miss_code", {4'h0, code}, {4'h0, last_code});
    chk("miss_kd", {7'h0, key_down}, 8'h0);

    // Reset in the middle of SCAN2.
    tick(); keys = 16'h0400; k0 = cyc; e0 = k0 + 3;
    while (cyc < e0 + D + 2 * S + 1) tick();
    chk("scan2_col", {4'h0, col}, 8'h04);
    reset_pulse("rst_scan2");

    // Reset while holding.
    press_check(16'h0040, 1'b0, "key6");
    tick();
    reset_pulse("rst_hold");

    for (int it = 0; it < 10; it++) begin
      rk = 16'h0;
      n = int'($urandom_range(1, 3));
      for (int i = 0; i < n; i++) rk[$urandom_range(0, 15)] = 1'b1;
      press_check(rk, 1'b0, "rand");
      release_check("rand");
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
